uart_rx_fifo_gen2: RTL and testbench

//  Second-generation synchronous FIFO for the UART receive path, between rx deserialiser and host read port.

---
 rtl/uart_rx_fifo_gen2.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_fifo_gen2.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_gen2.sv
// Synchronous receive FIFO between the UART deserialiser and the host read port.
// Define UART_RX_FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle reads.
module uart_rx_fifo_gen2 #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     wr_ack,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L     = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L     = LW'(AE_THRESH);

  // Pointer arithmetic relies on natural binary wrap, so DEPTH must be a power of two.
  generate
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_rx_fifo_gen2: DEPTH must be a power of two and at least 4");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH) || (AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_thresh
      $error("uart_rx_fifo_gen2: threshold parameter out of range");
    end
  endgenerate

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              wr_ack_q, wr_ack_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              rd_acc_s;
  logic              wr_acc_s;
  logic              mem_we_s;

  assign empty        = (level_q == LVL_ZERO);
  assign full         = (level_q == DEPTH_L);
  assign almost_full  = (level_q >= AF_L);
  assign almost_empty = (level_q <= AE_L);
  assign level        = level_q;
  assign wr_ack       = wr_ack_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO still takes a write when the same cycle pops a word; flush swallows both requests.
  assign rd_acc_s = rd_en & ~empty & ~flush;
  assign wr_acc_s = wr_en & ~flush & (~full | rd_acc_s);
  assign mem_we_s = wr_acc_s & ~rst;

  // Pointer, level and status-pulse next state.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    wr_ack_d    = wr_acc_s;
    overflow_d  = wr_en & ~flush & ~wr_acc_s;
    underflow_d = rd_en & ~flush & ~rd_acc_s;
    if (flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      level_d  = LVL_ZERO;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      level_q     <= LVL_ZERO;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef UART_RX_FIFO_FWFT_EN
  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_valid = ~empty;
`else
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Registered read port: data appears the cycle after the pop and holds otherwise.
  always_comb begin
    rd_valid_d = rd_acc_s;
    if (rd_acc_s) begin
      rd_data_d = mem_q[rd_ptr_q];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_gen2.sv
// Self-checking bench for uart_rx_fifo_gen2 (DEPTH=16, DATA_W=8) against a queue-based model.
// Honours UART_RX_FIFO_FWFT_EN so the same bench covers both read modes.
module tb_uart_rx_fifo_gen2;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, wr_ack, overflow, underflow;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] level;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic       e_ack = 1'b0, e_ovf = 1'b0, e_unf = 1'b0, e_rv = 1'b0;
  logic [7:0] e_rd = 8'h00;

  uart_rx_fifo_gen2 #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_ack(wr_ack), .overflow(overflow),
    .underflow(underflow), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("level", {27'd0, level}, n);
    chk("empty", {31'd0, empty}, {31'd0, n == 0});
    chk("full", {31'd0, full}, {31'd0, n == DEPTH});
    chk("almost_full", {31'd0, almost_full}, {31'd0, n >= AF});
    chk("almost_empty", {31'd0, almost_empty}, {31'd0, n <= AE});
    chk("wr_ack", {31'd0, wr_ack}, {31'd0, e_ack});
    chk("overflow", {31'd0, overflow}, {31'd0, e_ovf});
    chk("underflow", {31'd0, underflow}, {31'd0, e_unf});
`ifdef UART_RX_FIFO_FWFT_EN
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, n != 0});
    if (n != 0) chk("rd_data", {24'd0, rd_data}, {24'd0, q[0]});
`else
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, e_rv});
    chk("rd_data", {24'd0, rd_data}, {24'd0, e_rd});
`endif
  endtask

  // One clock cycle with the given requests; the model follows the FIFO rules directly.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f);
    logic racc, wacc;
    racc  = r && !f && (q.size() != 0);
    wacc  = w && !f && ((q.size() < DEPTH) || racc);
    e_ack = wacc;
    e_ovf = w && !f && !wacc;
    e_unf = r && !f && !racc;
    e_rv  = racc;
    if (f) begin
      q.delete();
    end else begin
      if (racc) e_rd = q.pop_front();
      if (wacc) q.push_back(d);
    end
    wr_en = w; wr_data = d; rd_en = r; flush = f;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    check_all();
  endtask

  task automatic pop(output logic [7:0] v);
`ifdef UART_RX_FIFO_FWFT_EN
    v = rd_data;
    step(1'b0, 8'h00, 1'b1, 1'b0);
`else
    step(1'b0, 8'h00, 1'b1, 1'b0);
    v = rd_data;
`endif
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE; rd_en = 1'b1; flush = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    q.delete();
    e_ack = 1'b0; e_ovf = 1'b0; e_unf = 1'b0; e_rv = 1'b0; e_rd = 8'h00;
    check_all();
  endtask

  initial begin
    logic [7:0] v;
    logic       w, r, f;

    // Reset state
    do_reset(2);

    // Fill, overflow, drain in order
    for (int i = 0; i < 16; i++) step(1'b1, i[7:0], 1'b0, 1'b0);
    chk("t2_full", {31'd0, full}, 32'd1);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("t2_overflow", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      pop(v);
      chk("t2_order", {24'd0, v}, i);
    end
    chk("t2_empty", {31'd0, empty}, 32'd1);

    // Simultaneous read/write on a full FIFO
    for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + i[7:0], 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t3_ack", {31'd0, wr_ack}, 32'd1);
    chk("t3_ovf", {31'd0, overflow}, 32'd0);
    chk("t3_level", {27'd0, level}, 32'd16);
    for (int i = 0; i < 16; i++) pop(v);
    chk("t3_last", {24'd0, v}, 32'h55);

    // Simultaneous read/write on an empty FIFO
    step(1'b1, 8'h33, 1'b1, 1'b0);
    chk("t4_unf", {31'd0, underflow}, 32'd1);
    chk("t4_ack", {31'd0, wr_ack}, 32'd1);
    chk("t4_level", {27'd0, level}, 32'd1);
    pop(v);
    chk("t4_data", {24'd0, v}, 32'h33);

    // Threshold sweep
    for (int i = 0; i < 13; i++) step(1'b1, 8'h10 + i[7:0], 1'b0, 1'b0);
    chk("t5_af13", {31'd0, almost_full}, 32'd0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    chk("t5_af14", {31'd0, almost_full}, 32'd1);
    for (int i = 0; i < 11; i++) pop(v);
    chk("t5_ae3", {31'd0, almost_empty}, 32'd0);
    pop(v);
    chk("t5_ae2", {31'd0, almost_empty}, 32'd1);
    pop(v);
    pop(v);

    // Flush with a concurrent write, then pointer-wrap traffic
    for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + i[7:0], 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("t6_level", {27'd0, level}, 32'd0);
    chk("t6_empty", {31'd0, empty}, 32'd1);
    chk("t6_ack", {31'd0, wr_ack}, 32'd0);
    chk("t6_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, i[7:0] ^ 8'h5A, 1'b0, 1'b0);
      pop(v);
      chk("t6_wrap", {24'd0, v}, {24'd0, i[7:0] ^ 8'h5A});
    end

    // Randomised traffic alternating write-heavy and read-heavy phases
    for (int i = 0; i < 600; i++) begin
      if (((i / 50) % 2) == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      f = ($urandom_range(0, 59) == 0);
      if (i == 320) do_reset(2);
      step(w, 8'($urandom_range(0, 255)), r, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
